// File: rtl/sss_multi_correlator.sv
// sss_multi_correlator: scores one received SSS sequence against NUM_CAND
// stored candidates, one candidate per clock. Streams each agreement score,
// tracks the best candidate (ties keep the lower index) and raises detected
// when the best score reaches the threshold captured with start.
module sss_multi_correlator #(
   parameter int SEQ_LEN  = 62,
   parameter int NUM_CAND = 8,
   parameter int IDX_W    = $clog2(NUM_CAND),
   parameter int SCORE_W  = $clog2(SEQ_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cand_we,
   input  logic [IDX_W-1:0]   cand_addr,
   input  logic [SEQ_LEN-1:0] cand_wdata,
   input  logic               start,
   input  logic [SEQ_LEN-1:0] rx_seq,
   input  logic [SCORE_W-1:0] threshold,
   output logic               busy,
   output logic               score_valid,
   output logic [IDX_W-1:0]   score_idx,
   output logic [SCORE_W-1:0] score,
   output logic               done,
   output logic [IDX_W-1:0]   best_idx,
   output logic [SCORE_W-1:0] best_score,
   output logic               detected
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 start_acc;

   // search context captured on the accepted start
   logic [SEQ_LEN-1:0]   rx_q;
   logic [SCORE_W-1:0]   thr_q;

   // candidate table; deliberately has no reset so entries survive it
   logic [SEQ_LEN-1:0]   cand_q [NUM_CAND];
   logic                 addr_ok;
   logic                 tbl_we;

   // score stage
   logic [SEQ_LEN-1:0]   match_v;
   logic [SCORE_W-1:0]   pop_d;
   logic                 score_valid_q;
   logic [IDX_W-1:0]     score_idx_q;
   logic [SCORE_W-1:0]   score_q;

   // best tracking
   logic [IDX_W-1:0]     best_idx_q, best_idx_d;
   logic [SCORE_W-1:0]   best_score_q, best_score_d;
   logic                 detected_q, detected_d;

   // Out-of-range addresses only exist when NUM_CAND is not a power of two.
   if (NUM_CAND == (1 << IDX_W)) begin : g_addr_full
      assign addr_ok = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = (32'(cand_addr) < NUM_CAND);
   end

   // Table writes are only honoured while idle so a search sees a stable table.
   assign tbl_we = cand_we && addr_ok && (state_q == S_IDLE);

   // Candidate table storage.
   always_ff @(posedge clk) begin
      if (tbl_we) begin
         cand_q[cand_addr] <= cand_wdata;
      end
   end

   // Agreement count: number of positions where rx and the candidate are equal.
   always_comb begin
      match_v = ~(rx_q ^ cand_q[idx_q]);
      pop_d   = '0;
      for (int b = 0; b < SEQ_LEN; b++) begin
         pop_d = pop_d + SCORE_W'(match_v[b]);
      end
   end

   // FSM next state: IDLE -> RUN (one candidate per cycle) -> DRAIN -> DONE.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      start_acc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               idx_d     = '0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = S_DRAIN;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, index and captured search context.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         rx_q    <= '0;
         thr_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (start_acc) begin
            rx_q  <= rx_seq;
            thr_q <= threshold;
         end
      end
   end

   // Registered score stage: one result per RUN cycle, no backpressure.
   always_ff @(posedge clk) begin
      if (reset) begin
         score_valid_q <= 1'b0;
         score_idx_q   <= '0;
         score_q       <= '0;
      end else begin
         score_valid_q <= (state_q == S_RUN);
         if (state_q == S_RUN) begin
            score_idx_q <= idx_q;
            score_q     <= pop_d;
         end
      end
   end

   // Best tracking; strict '>' keeps the lower index on ties. Detection uses
   // the post-update best so the final score is included when DONE is entered.
   always_comb begin
      best_score_d = best_score_q;
      best_idx_d   = best_idx_q;
      detected_d   = detected_q;
      if (start_acc) begin
         best_score_d = '0;
         best_idx_d   = '0;
         detected_d   = 1'b0;
      end else if (score_valid_q &&
                   ((score_idx_q == '0) || (score_q > best_score_q))) begin
         best_score_d = score_q;
         best_idx_d   = score_idx_q;
      end
      if (state_q == S_DRAIN) begin
         detected_d = (best_score_d >= thr_q);
      end
   end

   // Best/detect registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         best_score_q <= '0;
         best_idx_q   <= '0;
         detected_q   <= 1'b0;
      end else begin
         best_score_q <= best_score_d;
         best_idx_q   <= best_idx_d;
         detected_q   <= detected_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign score_valid = score_valid_q;
   assign score_idx   = score_idx_q;
   assign score       = score_q;
   assign best_idx    = best_idx_q;
   assign best_score  = best_score_q;
   assign detected    = detected_q;

endmodule
